// File: rtl/regfile_operand_fetch.sv
// Operand-fetch initiator for a two-read/one-write register file with registered reads.
// Optional REGFILE_BYPASS_EN: same-edge write hazards are forwarded instead of re-read.
module regfile_operand_fetch #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_op1,
    output logic [DATA_W-1:0] resp_op2,
    output logic              resp_err,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ra1_q, ra1_d, ra2_q, ra2_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic              err_q, err_d;
    logic              h1_q, h1_d, h2_q, h2_d;
    logic              in1, in2, hz1, hz2;
`ifdef REGFILE_BYPASS_EN
    logic [DATA_W-1:0] wbd_q, wbd_d;
`endif

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    assign rf_write_enable = wb_valid && in_range(wb_addr);
    assign rf_write_addr   = wb_addr;
    assign rf_write_data   = wb_data;

    // The latched request indices double as the read-address registers.
    assign rf_read_addr1 = ra1_q;
    assign rf_read_addr2 = ra2_q;
    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == RESP);
    assign resp_op1      = op1_q;
    assign resp_op2      = op2_q;
    assign resp_err      = err_q;

    assign in1 = in_range(ra1_q);
    assign in2 = in_range(ra2_q);
    assign hz1 = rf_write_enable && (rf_write_addr == ra1_q);
    assign hz2 = rf_write_enable && (rf_write_addr == ra2_q);

    always_comb begin
        state_d = state_q;
        ra1_d   = ra1_q;
        ra2_d   = ra2_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        err_d   = err_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
`ifdef REGFILE_BYPASS_EN
        wbd_d   = wbd_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ra1_d   = req_rs1;
                    ra2_d   = req_rs2;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                h1_d    = hz1;
                h2_d    = hz2;
`ifdef REGFILE_BYPASS_EN
                wbd_d   = wb_data;
`endif
                state_d = CAPTURE;
            end
            CAPTURE: begin
`ifdef REGFILE_BYPASS_EN
                op1_d   = !in1 ? '0 : (h1_q ? wbd_q : rf_read_data1);
                op2_d   = !in2 ? '0 : (h2_q ? wbd_q : rf_read_data2);
                err_d   = !in1 || !in2;
                state_d = RESP;
`else
                if (h1_q || h2_q) begin
                    // Addresses are still driven, so this edge is the re-read: one cycle per retry.
                    h1_d = hz1;
                    h2_d = hz2;
                end else begin
                    op1_d   = in1 ? rf_read_data1 : '0;
                    op2_d   = in2 ? rf_read_data2 : '0;
                    err_d   = !in1 || !in2;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra1_q   <= '0;
            ra2_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            err_q   <= 1'b0;
            h1_q    <= 1'b0;
            h2_q    <= 1'b0;
`ifdef REGFILE_BYPASS_EN
            wbd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            err_q   <= err_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
`ifdef REGFILE_BYPASS_EN
            wbd_q   <= wbd_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Scoreboard bench for regfile_operand_fetch with a behavioural registered-read register file.
module tb_regfile_operand_fetch;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 8;
`ifdef REGFILE_BYPASS_EN
    localparam int HZ_LAT = 2;
`else
    localparam int HZ_LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_rs1, req_rs2;
    logic              resp_valid, resp_ready;
    logic [DATA_W-1:0] resp_op1, resp_op2;
    logic              resp_err;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rf_read_addr1, rf_read_addr2;
    logic [DATA_W-1:0] rf_read_data1, rf_read_data2;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;

    always #5 clk = ~clk;

    regfile_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_op1(resp_op1), .resp_op2(resp_op2), .resp_err(resp_err),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data)
    );

    // Register file: reads sampled at the edge return pre-write contents.
    logic [DATA_W-1:0] rf_mem [0:NUM_REGS-1] = '{default: '0};
    always @(posedge clk) begin
        rf_read_data1 <= (rf_read_addr1 < NUM_REGS) ? rf_mem[rf_read_addr1[2:0]] : 16'hDEAD;
        rf_read_data2 <= (rf_read_addr2 < NUM_REGS) ? rf_mem[rf_read_addr2[2:0]] : 16'hDEAD;
        if (rf_write_enable) rf_mem[rf_write_addr[2:0]] <= rf_write_data;
    end

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] gold [0:NUM_REGS-1] = '{default: '0};
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] exp_op(input logic [ADDR_W-1:0] rs, input logic hz,
                                                 input logic [ADDR_W-1:0] ha, input logic [DATA_W-1:0] hd);
        if (rs >= NUM_REGS) return '0;
        if (hz && ha == rs) return hd;
        return gold[rs[2:0]];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("resp_op1", resp_op1, e.op1);
                check("resp_op2", resp_op2, e.op2);
                check("resp_err", resp_err, e.err);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        #1;
        check("wb_enable", rf_write_enable, a < NUM_REGS);
        cyc();
        wb_valid = 1'b0;
        if (a < NUM_REGS) gold[a[2:0]] = d;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic hz, input logic [ADDR_W-1:0] ha,
                         input logic [DATA_W-1:0] hd, output int lat);
        exp_t e;
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        e.op1 = exp_op(rs1, hz, ha, hd);
        e.op2 = exp_op(rs2, hz, ha, hd);
        e.err = (rs1 >= NUM_REGS) || (rs2 >= NUM_REGS);
        exp_q.push_back(e);
        cyc();
        req_valid = 1'b0;
        wb_valid  = hz;
        wb_addr   = ha;
        wb_data   = hd;
        lat = 0;
        while (lat < 20) begin
            cyc();
            wb_valid = 1'b0;
            lat++;
            @(negedge clk);
            if (resp_valid) break;
        end
        if (hz && ha < NUM_REGS) gold[ha[2:0]] = hd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, w;
        logic [DATA_W-1:0] h1, h2, d;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b1 [0:3];
        logic [ADDR_W-1:0] b2 [0:3];
        exp_t e;

        rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
        resp_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_op1", resp_op1, 16'h0);
        check("rst_op2", resp_op2, 16'h0);
        check("rst_err", resp_err, 1'b0);
        check("rst_raddr1", rf_read_addr1, 4'h0);
        check("rst_raddr2", rf_read_addr2, 4'h0);

        cyc();
        wb_write(4'd3, 16'h1234);
        wb_write(4'd5, 16'hBEEF);
        fetch(4'd3, 4'd5, 1'b0, '0, '0, lat);
        check("lat_basic", lat, 2);

        cyc();
        wb_write(4'd2, 16'h0042);
        fetch(4'd9, 4'd2, 1'b0, '0, '0, lat);
        check("lat_oob", lat, 2);
        cyc();
        wb_write(4'd12, 16'h7777);

        wb_write(4'd4, 16'h0001);
        fetch(4'd4, 4'd0, 1'b1, 4'd4, 16'hA5A5, lat);
        check("lat_hazard", lat, HZ_LAT);

        cyc();
        resp_ready = 1'b0;
        fetch(4'd3, 4'd5, 1'b0, '0, '0, lat);
        check("lat_hold", lat, 2);
        h1 = gold[3];
        h2 = gold[5];
        for (int i = 0; i < 5; i++) begin
            cyc();
            a = (i % 2 == 0) ? 4'd3 : 4'd5;
            d = DATA_W'($urandom);
            wb_valid = 1'b1; wb_addr = a; wb_data = d;
            gold[a[2:0]] = d;
            @(negedge clk);
            check("hold_op1", resp_op1, h1);
            check("hold_op2", resp_op2, h2);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_resp_valid", resp_valid, 1'b1);
        end
        cyc();
        wb_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("release_resp_valid", resp_valid, 1'b0);
        check("release_req_ready", req_ready, 1'b1);

        cyc();
        req_valid = 1'b1; req_rs1 = 4'd3; req_rs2 = 4'd5;
        cyc();
        req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", resp_valid, 1'b0);
        check("midrst_op1", resp_op1, 16'h0);
        check("midrst_op2", resp_op2, 16'h0);
        check("midrst_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_resp", resp_valid, 1'b0);
        end

        b1[0] = 4'd1; b2[0] = 4'd2;
        b1[1] = 4'd3; b2[1] = 4'd5;
        b1[2] = 4'd4; b2[2] = 4'd9;
        b1[3] = 4'd7; b2[3] = 4'd0;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            req_valid = 1'b1; req_rs1 = b1[k]; req_rs2 = b2[k];
            w = 0;
            @(negedge clk);
            while (!req_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("b2b_accept", req_ready, 1'b1);
            e.op1 = exp_op(b1[k], 1'b0, '0, '0);
            e.op2 = exp_op(b2[k], 1'b0, '0, '0);
            e.err = (b1[k] >= NUM_REGS) || (b2[k] >= NUM_REGS);
            exp_q.push_back(e);
        end
        cyc();
        req_valid = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("b2b_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
